// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS waveform path.
//   dds_state_e  - phase-accumulator control state
//   DDS_ACC_W    - default accumulator / tuning-word width
//   DDS_ADDR_W   - default waveform ROM address width
//   DDS_ROM_LAT  - ROM read latency; sets the depth of the q_valid delay line
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } dds_state_e;

   localparam int unsigned DDS_ACC_W   = 32;
   localparam int unsigned DDS_ADDR_W  = 12;
   localparam int unsigned DDS_ROM_LAT = 1;

endpackage

// File: rtl/dds_ftw_shadow.sv
// dds_ftw_shadow: frequency tuning word holding registers.
// Holds the active FTW used by the accumulator plus a shadow copy for loads that
// must wait until the next phase wrap, so the frequency only changes on a period
// boundary.
// Ports:
//   clock, rst_n  - clock, asynchronous active-low reset
//   ftw, ftw_load - tuning word and its load strobe
//   sync_update   - with ftw_load: 1 = defer to next wrap (only while busy)
//   busy          - accumulator is running (not IDLE)
//   carry         - strobe that commits a pending shadow value (wrap or stop-to-idle)
//   ftw_active    - tuning word currently accumulated
//   ftw_pending   - shadow holds a deferred tuning word
module dds_ftw_shadow
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W = DDS_ACC_W
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [ACC_W-1:0] ftw,
   input  logic             ftw_load,
   input  logic             sync_update,
   input  logic             busy,
   input  logic             carry,
   output logic [ACC_W-1:0] ftw_active,
   output logic             ftw_pending
);

   logic [ACC_W-1:0] active_q, active_d;
   logic [ACC_W-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             load_now;
   logic             load_defer;

   always_comb begin
      active_d   = active_q;
      shadow_d   = shadow_q;
      pending_d  = pending_q;
      load_now   = ftw_load & ~(busy & sync_update);
      load_defer = ftw_load & busy & sync_update;

      if (carry && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      // A deferred load coinciding with a commit: old shadow is applied above and
      // the new word waits for the following wrap.
      if (load_defer) begin
         shadow_d  = ftw;
         pending_d = 1'b1;
      end
      if (load_now) begin
         active_d = ftw;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   assign ftw_active  = active_q;
   assign ftw_pending = pending_q;

endmodule

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase-accumulator address generator for the DDS waveform ROMs.
// Accumulates the active FTW every clock while running and forms the ROM address
// from the accumulator's top ADDR_W bits plus a phase offset. Stop is phase
// coherent: the block keeps running until the next accumulator overflow and
// drops out without emitting the wrapped sample. ADDR_W must not exceed ACC_W.
// Ports:
//   clock, rst_n        - clock, asynchronous active-low reset
//   start, stop         - single-cycle start / coherent stop requests
//   ftw, ftw_load       - tuning word and load strobe
//   sync_update         - defer the loaded FTW to the next wrap while busy
//   phase_ofs           - phase offset added to the address every cycle
//   address, addr_valid - registered ROM address and its valid flag
//   q_valid             - addr_valid delayed by the ROM read latency
//   wrap                - pulse registered with the post-overflow sample
//   busy, ftw_pending   - not IDLE / deferred FTW waiting for a wrap
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W  = DDS_ACC_W,
   parameter int unsigned ADDR_W = DDS_ADDR_W
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ACC_W-1:0]  ftw,
   input  logic              ftw_load,
   input  logic              sync_update,
   input  logic [ADDR_W-1:0] phase_ofs,
   output logic [ADDR_W-1:0] address,
   output logic              addr_valid,
   output logic              q_valid,
   output logic              wrap,
   output logic              busy,
   output logic              ftw_pending
);

   dds_state_e        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic              addr_valid_q, addr_valid_d;
   logic              wrap_q, wrap_d;
   logic [DDS_ROM_LAT-1:0] vld_pipe_q;

   logic [ACC_W:0]    sum;
   logic              carry;
   logic [ADDR_W-1:0] acc_addr;
   logic [ACC_W-1:0]  ftw_active;
   logic              commit;

   assign sum      = {1'b0, acc_q} + {1'b0, ftw_active};
   assign carry    = sum[ACC_W];
   assign acc_addr = sum[ACC_W-1 -: ADDR_W] + phase_ofs;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      address_d    = address_q;
      addr_valid_d = addr_valid_q;
      wrap_d       = 1'b0;
      commit       = 1'b0;

      unique case (state_q)
         IDLE: begin
            addr_valid_d = 1'b0;
            if (start) begin
               acc_d        = '0;
               address_d    = phase_ofs;
               addr_valid_d = 1'b1;
               state_d      = RUN;
            end
         end
         RUN: begin
            acc_d        = sum[ACC_W-1:0];
            address_d    = acc_addr;
            addr_valid_d = 1'b1;
            wrap_d       = carry;
            commit       = carry;
            if (stop) state_d = STOPPING;
         end
         STOPPING: begin
            if (start) begin
               // Cancelled stop: behave exactly like a RUN cycle, phase untouched.
               acc_d        = sum[ACC_W-1:0];
               address_d    = acc_addr;
               addr_valid_d = 1'b1;
               wrap_d       = carry;
               commit       = carry;
               state_d      = RUN;
            end else if (carry || (ftw_active == '0)) begin
               // Overflow sample is swallowed; any deferred FTW is committed on the
               // way to IDLE so it is not left stranded.
               acc_d        = '0;
               address_d    = '0;
               addr_valid_d = 1'b0;
               commit       = 1'b1;
               state_d      = IDLE;
            end else begin
               acc_d        = sum[ACC_W-1:0];
               address_d    = acc_addr;
               addr_valid_d = 1'b1;
            end
         end
         default: begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         address_q    <= '0;
         addr_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         address_q    <= address_d;
         addr_valid_q <= addr_valid_d;
         wrap_q       <= wrap_d;
      end
   end

   // Delay line matching the ROM read latency.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
      end else begin
         vld_pipe_q[0] <= addr_valid_q;
         for (int i = 1; i < int'(DDS_ROM_LAT); i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
         end
      end
   end

   dds_ftw_shadow #(
      .ACC_W (ACC_W)
   ) u_ftw_shadow (
      .clock       (clock),
      .rst_n       (rst_n),
      .ftw         (ftw),
      .ftw_load    (ftw_load),
      .sync_update (sync_update),
      .busy        (busy),
      .carry       (commit),
      .ftw_active  (ftw_active),
      .ftw_pending (ftw_pending)
   );

   assign address    = address_q;
   assign addr_valid = addr_valid_q;
   assign q_valid    = vld_pipe_q[DDS_ROM_LAT-1];
   assign wrap       = wrap_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb_dds_phase_acc: directed self-checking bench for dds_phase_acc.
module tb_dds_phase_acc;

   logic        clock;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [31:0] ftw;
   logic        ftw_load;
   logic        sync_update;
   logic [11:0] phase_ofs;
   logic [11:0] address;
   logic        addr_valid;
   logic        q_valid;
   logic        wrap;
   logic        busy;
   logic        ftw_pending;

   int errors = 0;
   int checks = 0;

   dds_phase_acc #(
      .ACC_W  (32),
      .ADDR_W (12)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .ftw         (ftw),
      .ftw_load    (ftw_load),
      .sync_update (sync_update),
      .phase_ofs   (phase_ofs),
      .address     (address),
      .addr_valid  (addr_valid),
      .q_valid     (q_valid),
      .wrap        (wrap),
      .busy        (busy),
      .ftw_pending (ftw_pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".address"}, {20'd0, address}, 32'd0);
      check({tag, ".addr_valid"}, {31'd0, addr_valid}, 32'd0);
      check({tag, ".q_valid"}, {31'd0, q_valid}, 32'd0);
      check({tag, ".wrap"}, {31'd0, wrap}, 32'd0);
      check({tag, ".busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".ftw_pending"}, {31'd0, ftw_pending}, 32'd0);
   endtask

   initial begin
      logic [11:0] exp_addr;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; ftw = '0; ftw_load = 1'b0;
      sync_update = 1'b0; phase_ofs = '0;
      tick(); tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Ramp: step of one address per sample, wrap on the 4097th sample.
      ftw = 32'h0010_0000; ftw_load = 1'b1;
      tick();
      ftw_load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("ramp.first_addr", {20'd0, address}, 32'h0);
      check("ramp.first_valid", {31'd0, addr_valid}, 32'd1);
      check("ramp.first_qvalid", {31'd0, q_valid}, 32'd0);
      check("ramp.busy", {31'd0, busy}, 32'd1);
      for (int k = 1; k < 4096; k++) begin
         tick();
         check("ramp.addr", {20'd0, address}, k);
         check("ramp.wrap", {31'd0, wrap}, 32'd0);
         check("ramp.qvalid", {31'd0, q_valid}, 32'd1);
      end
      tick();
      check("ramp.wrap_addr", {20'd0, address}, 32'h0);
      check("ramp.wrap_pulse", {31'd0, wrap}, 32'd1);
      tick();
      check("ramp.after_wrap_addr", {20'd0, address}, 32'h1);
      check("ramp.after_wrap_pulse", {31'd0, wrap}, 32'd0);

      // Asynchronous reset mid-RUN.
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      check_all_zero("post_rst_idle");
      phase_ofs = 12'h123; start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_restart.addr", {20'd0, address}, 32'h123);
      check("rst_restart.valid", {31'd0, addr_valid}, 32'd1);
      check("rst_restart.qvalid", {31'd0, q_valid}, 32'd0);
      tick();
      check("rst_restart.ftw0_hold", {20'd0, address}, 32'h123);
      check("rst_restart.qvalid2", {31'd0, q_valid}, 32'd1);

      // ftw_active is 0: stop reaches IDLE one cycle after STOPPING.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("ftw0_stop.busy_stopping", {31'd0, busy}, 32'd1);
      tick();
      check("ftw0_stop.busy_idle", {31'd0, busy}, 32'd0);
      check("ftw0_stop.valid", {31'd0, addr_valid}, 32'd0);
      check("ftw0_stop.addr", {20'd0, address}, 32'h0);

      // Offset wraps silently; accumulator wrap at sample 257.
      ftw = 32'h0100_0000; ftw_load = 1'b1;
      tick();
      ftw_load = 1'b0; phase_ofs = 12'h800; start = 1'b1;
      tick();
      start = 1'b0;
      check("ofs.first", {20'd0, address}, 32'h800);
      for (int k = 1; k < 256; k++) begin
         tick();
         check("ofs.addr", {20'd0, address}, (32'h800 + k * 32'h10) & 32'hFFF);
         check("ofs.wrap", {31'd0, wrap}, 32'd0);
      end
      tick();
      check("ofs.wrap_addr", {20'd0, address}, 32'h800);
      check("ofs.wrap_pulse", {31'd0, wrap}, 32'd1);

      // Deferred FTW update: step stays 0x10 until the wrap, then 0x20.
      phase_ofs = 12'h000;
      tick();
      check("sync.pre", {20'd0, address}, 32'h010);
      ftw = 32'h0200_0000; ftw_load = 1'b1; sync_update = 1'b1;
      tick();
      ftw_load = 1'b0; sync_update = 1'b0;
      check("sync.load_addr", {20'd0, address}, 32'h020);
      check("sync.pending", {31'd0, ftw_pending}, 32'd1);
      exp_addr = 12'h020;
      for (int k = 0; k < 253; k++) begin
         tick();
         exp_addr = exp_addr + 12'h010;
         check("sync.old_step", {20'd0, address}, {20'd0, exp_addr});
         check("sync.still_pending", {31'd0, ftw_pending}, 32'd1);
      end
      tick();
      check("sync.wrap_addr", {20'd0, address}, 32'h000);
      check("sync.wrap_pulse", {31'd0, wrap}, 32'd1);
      check("sync.pending_clr", {31'd0, ftw_pending}, 32'd0);
      tick();
      check("sync.new_step1", {20'd0, address}, 32'h020);
      tick();
      check("sync.new_step2", {20'd0, address}, 32'h040);

      // Immediate FTW load: new step seen two cycles after the strobe.
      ftw = 32'h0100_0000; ftw_load = 1'b1; sync_update = 1'b0;
      tick();
      ftw_load = 1'b0;
      check("imm.n1_old_step", {20'd0, address}, 32'h060);
      check("imm.no_pending", {31'd0, ftw_pending}, 32'd0);
      tick();
      check("imm.n2_new_step", {20'd0, address}, 32'h070);

      // Coherent stop, cancel by start, repeated stop ignored.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop.stopping_addr", {20'd0, address}, 32'h080);
      check("stop.stopping_busy", {31'd0, busy}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("stop.cancel_no_jump", {20'd0, address}, 32'h090);
      stop = 1'b1;
      tick();
      check("stop.again", {20'd0, address}, 32'h0A0);
      tick();
      stop = 1'b0;
      check("stop.repeat", {20'd0, address}, 32'h0B0);
      exp_addr = 12'h0B0;
      for (int k = 0; k < 244; k++) begin
         tick();
         exp_addr = exp_addr + 12'h010;
         check("stop.drain_addr", {20'd0, address}, {20'd0, exp_addr});
         check("stop.drain_valid", {31'd0, addr_valid}, 32'd1);
         check("stop.drain_wrap", {31'd0, wrap}, 32'd0);
      end
      tick();
      check("stop.end_valid", {31'd0, addr_valid}, 32'd0);
      check("stop.end_busy", {31'd0, busy}, 32'd0);
      check("stop.end_wrap", {31'd0, wrap}, 32'd0);
      check("stop.end_addr", {20'd0, address}, 32'h0);
      check("stop.end_qvalid_lag", {31'd0, q_valid}, 32'd1);
      tick();
      check("stop.qvalid_off", {31'd0, q_valid}, 32'd0);

      // Start and stop together in RUN: stop wins (ftw 0 exits next cycle).
      ftw = 32'h0; ftw_load = 1'b1;
      tick();
      ftw_load = 1'b0; start = 1'b1;
      tick();
      stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("start_stop.busy", {31'd0, busy}, 32'd1);
      tick();
      check("start_stop.idle", {31'd0, busy}, 32'd0);
      check("start_stop.valid", {31'd0, addr_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
